// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: valid/ready byte stream leaving the frame receiver.
// The master side (receiver) drives data/valid; the slave side (consumer) drives ready.
interface serial_frame_rx_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a serial bit stream for SYNC_PATTERN, then deserialises
// the following FRAME_BYTES bytes into a first-word fall-through FIFO that is
// presented on byte_if.
// Optional build macro: PARITY_CHECK_EN -- each payload byte is followed by an
// even-parity bit; bad bytes are dropped and flagged on parity_err.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_HUNT | shifting bits through the window, looking for SYNC_PATTERN
// ST_RECV | locked; assembling payload bytes until FRAME_BYTES are done
module serial_frame_rx #(
    parameter logic [7:0] SYNC_PATTERN = 8'hA5,
    parameter int         FRAME_BYTES  = 4,
    parameter int         DEPTH        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_en,
    input  logic              msb_first,
    input  logic              clr_err,
    serial_frame_rx_if.master byte_if,
    output logic              sync_lock,
    output logic              overflow,
    output logic              parity_err
);
    localparam int AW = $clog2(DEPTH);
`ifdef PARITY_CHECK_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif
    localparam logic [7:0]  LAST_BYTE = 8'(FRAME_BYTES - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic {ST_HUNT = 1'b0, ST_RECV = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_window;
    logic [3:0]    r_bit_cnt;
    logic [3:0]    r_fill;
    logic [7:0]    r_byte_cnt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_out_data;
    logic          r_overflow;

    logic [7:0]    w_win_shift;
    logic [7:0]    w_byte;
    logic          w_sync_hit;
    logic          w_byte_done;
    logic          w_frame_done;
    logic          w_parity_bad;
    logic          w_commit;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW-1:0] w_rd_ptr_next;
    logic [AW:0]   w_count_next;

    assign w_win_shift = msb_first ? {r_window[6:0], sin} : {sin, r_window[7:1]};

    // r_fill gates matching so a short sync word cannot hit on reset zeros
    assign w_sync_hit   = sin_en && (r_state == ST_HUNT) && (r_fill >= 4'd7)
                          && (w_win_shift == SYNC_PATTERN);
    assign w_byte_done  = sin_en && (r_state == ST_RECV) && (r_bit_cnt == LAST_BIT);
    assign w_frame_done = w_byte_done && (r_byte_cnt == LAST_BYTE);

`ifdef PARITY_CHECK_EN
    // the parity bit does not shift, so the window already holds the byte
    assign w_byte       = r_window;
    assign w_parity_bad = w_byte_done && (^{r_window, sin});
`else
    assign w_byte       = w_win_shift;
    assign w_parity_bad = 1'b0;
`endif

    assign w_commit = w_byte_done && !w_parity_bad;
    assign w_pop    = (r_count != '0) && byte_if.out_ready;
    assign w_push   = w_commit && ((r_count != FULL_CNT) || w_pop);
    assign w_drop   = w_commit && !w_push;

    assign w_rd_ptr_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    // FIFO occupancy after this edge
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (AW + 1)'(1);
            2'b01:   w_count_next = r_count - (AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT;
        else        r_state <= w_state_next;
    end

    // FSM next state: lock on sync, release after the last byte of the frame
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT: if (w_sync_hit)   w_state_next = ST_RECV;
            ST_RECV: if (w_frame_done) w_state_next = ST_HUNT;
            default: w_state_next = ST_HUNT;
        endcase
    end

    // Serial window, bit/byte counters and post-reset fill counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window   <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_fill     <= '0;
        end else if (sin_en) begin
            if (r_fill != 4'd8) r_fill <= r_fill + 4'd1;
            if (r_state == ST_HUNT) begin
                if (w_sync_hit) begin
                    r_window   <= '0;
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                end else begin
                    r_window <= w_win_shift;
                end
            end else begin
                r_bit_cnt <= w_byte_done ? 4'd0 : r_bit_cnt + 4'd1;
                if (w_byte_done)       r_byte_cnt <= r_byte_cnt + 8'd1;
                if (w_frame_done)      r_window   <= '0;
                else if (r_bit_cnt < 4'd8) r_window <= w_win_shift;
            end
        end
    end

    // FIFO storage; never read before written, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_byte;
    end

    // FIFO pointers, count and registered head byte (holds when emptied)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (w_count_next != '0) begin
                // the new head may be the byte being written this edge
                r_out_data <= (w_push && (w_rd_ptr_next == r_wr_ptr)) ? w_byte
                                                                      : r_mem[w_rd_ptr_next];
            end
        end
    end

    // Sticky overflow: a set in the same cycle beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;
        else if (clr_err) r_overflow <= 1'b0;
    end

`ifdef PARITY_CHECK_EN
    logic r_parity_err;

    // Sticky parity error: a set in the same cycle beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_parity_err <= 1'b0;
        else if (w_parity_bad) r_parity_err <= 1'b1;
        else if (clr_err)      r_parity_err <= 1'b0;
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign sync_lock         = (r_state == ST_RECV);
    assign overflow          = r_overflow;
    assign byte_if.out_valid = (r_count != '0);
    assign byte_if.out_data  = r_out_data;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table-driven frames, hand-written corner sequences
// and a randomized run against a bit-level behavioural model.
module tb_serial_frame_rx;
`ifdef PARITY_CHECK_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic sin       = 1'b0;
    logic sin_en    = 1'b0;
    logic msb_first = 1'b1;
    logic clr_err   = 1'b0;
    logic sl1, ov1, pe1, sl2, ov2, pe2;

    serial_frame_rx_if if1 ();
    serial_frame_rx_if if2 ();

    serial_frame_rx #(.SYNC_PATTERN(8'hA5), .FRAME_BYTES(4), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .msb_first(msb_first),
        .clr_err(clr_err), .byte_if(if1), .sync_lock(sl1), .overflow(ov1), .parity_err(pe1));

    serial_frame_rx #(.SYNC_PATTERN(8'h1E), .FRAME_BYTES(6), .DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .msb_first(msb_first),
        .clr_err(clr_err), .byte_if(if2), .sync_lock(sl2), .overflow(ov2), .parity_err(pe2));

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin    = b;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic lsb_order);
        for (int i = 0; i < 8; i++) send_bit(lsb_order ? v[i] : v[7-i]);
    endtask

    task automatic send_pbyte(input logic [7:0] v, input logic lsb_order);
        send_byte(v, lsb_order);
`ifdef PARITY_CHECK_EN
        send_bit(^v);
`endif
    endtask

    task automatic do_reset();
        sin_en  = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
    endtask

    // popped bytes, captured on the edge-opposite sample point
    logic [7:0] got1[$];
    logic [7:0] got2[$];
    bit         collect_en = 1'b0;

    always @(negedge clk) begin
        if (collect_en) begin
            if (if1.out_valid && if1.out_ready) got1.push_back(if1.out_data);
            if (if2.out_valid && if2.out_ready) got2.push_back(if2.out_data);
        end
    end

    task automatic drain1(input int n);
        got1.delete();
        collect_en     = 1'b1;
        if1.out_ready  = 1'b1;
        repeat (n) tick();
        if1.out_ready  = 1'b0;
        collect_en     = 1'b0;
    endtask

    task automatic chk_got1(input string tag, input logic [31:0] exp);
        chk({tag, "_count"}, got1.size(), 4);
        for (int k = 0; k < 4 && k < got1.size(); k++)
            chk({tag, "_byte"}, got1[k], exp[31-8*k -: 8]);
    endtask

    typedef struct {
        logic        msb;
        logic        lsb_order;
        logic [31:0] pay;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[5];

    task automatic run_vec(input vec_t v, input string tag);
        msb_first     = v.msb;
        if1.out_ready = 1'b1;
        got1.delete();
        collect_en    = 1'b1;
        send_byte(8'hA5, v.lsb_order);
        chk({tag, "_lock"}, sl1, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) chk({tag, "_lock_hold"}, sl1, 1);
            send_pbyte(v.pay[31-8*k -: 8], v.lsb_order);
        end
        chk({tag, "_unlock"}, sl1, 0);
        repeat (4) tick();
        collect_en = 1'b0;
        chk_got1(tag, v.exp);
        chk({tag, "_ovf"}, ov1, 0);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_win    [2];
    int         m_seen   [2];
    int         m_rbits  [2];
    int         m_rbytes [2];
    int         m_cnt    [2];
    bit         m_lock   [2];
    bit         m_ovf    [2];
    bit         m_perr   [2];
    logic [7:0] m_last   [2];
    logic [7:0] m_fifo   [2][4];
    bit         model_en = 1'b0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_win[d] = 8'h00; m_seen[d] = 0; m_rbits[d] = 0; m_rbytes[d] = 0;
            m_cnt[d] = 0; m_lock[d] = 1'b0; m_ovf[d] = 1'b0; m_perr[d] = 1'b0;
            m_last[d] = 8'h00;
        end
    endtask

    task automatic model_step(input int d, input logic rdy, input logic [7:0] sp, input int nb);
        logic [7:0] nw;
        logic [7:0] cb;
        bit done, good, pop, oset, pset;
        done = 0; good = 0; oset = 0; pset = 0; cb = 8'h00;
        pop = (m_cnt[d] > 0) && rdy;
        if (sin_en) begin
            nw = msb_first ? {m_win[d][6:0], sin} : {sin, m_win[d][7:1]};
            if (m_seen[d] < 8) m_seen[d]++;
            if (!m_lock[d]) begin
                if (m_seen[d] >= 8 && nw == sp) begin
                    m_lock[d] = 1'b1; m_win[d] = 8'h00; m_rbits[d] = 0; m_rbytes[d] = 0;
                end else begin
                    m_win[d] = nw;
                end
            end else begin
                if (m_rbits[d] < 8) m_win[d] = nw;
                m_rbits[d]++;
                if (m_rbits[d] == BPB) begin
                    done = 1; good = 1; cb = m_win[d];
                    if (BPB == 9 && (^{cb, sin}) != 1'b0) begin good = 0; pset = 1; end
                    m_rbits[d] = 0;
                    m_rbytes[d]++;
                    if (m_rbytes[d] == nb) begin m_lock[d] = 1'b0; m_win[d] = 8'h00; end
                end
            end
        end
        if (pop) begin
            for (int i = 0; i < 3; i++) m_fifo[d][i] = m_fifo[d][i+1];
            m_cnt[d]--;
        end
        if (done && good) begin
            if (m_cnt[d] < 4) begin m_fifo[d][m_cnt[d]] = cb; m_cnt[d]++; end
            else oset = 1;
        end
        if (oset) m_ovf[d] = 1'b1;
        else if (clr_err) m_ovf[d] = 1'b0;
        if (pset) m_perr[d] = 1'b1;
        else if (clr_err) m_perr[d] = 1'b0;
        if (m_cnt[d] > 0) m_last[d] = m_fifo[d][0];
    endtask

    always @(posedge clk) begin
        if (model_en) begin
            model_step(0, if1.out_ready, 8'hA5, 4);
            model_step(1, if2.out_ready, 8'h1E, 6);
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            chk("rnd_valid1", if1.out_valid, m_cnt[0] != 0);
            chk("rnd_data1",  if1.out_data,  m_last[0]);
            chk("rnd_lock1",  sl1,           m_lock[0]);
            chk("rnd_ovf1",   ov1,           m_ovf[0]);
            chk("rnd_perr1",  pe1,           m_perr[0]);
            chk("rnd_valid2", if2.out_valid, m_cnt[1] != 0);
            chk("rnd_data2",  if2.out_data,  m_last[1]);
            chk("rnd_lock2",  sl2,           m_lock[1]);
            chk("rnd_ovf2",   ov2,           m_ovf[1]);
            chk("rnd_perr2",  pe2,           m_perr[1]);
        end
    end

    initial begin
        logic [7:0] dir_pay [6];
        logic [7:0] bits_q [$];
        logic [8:0] bits;
        logic [7:0] b;
        int         r;
        bit         lo;

        if1.out_ready = 1'b0;
        if2.out_ready = 1'b1;

        // {msb_first, send LSB-first, payload bytes, expected bytes}
        tbl[0] = '{1'b1, 1'b0, 32'h11223344, 32'h11223344};
        tbl[1] = '{1'b1, 1'b1, 32'h11223344, 32'h8844CC22};
        tbl[2] = '{1'b0, 1'b1, 32'h3C0180F0, 32'h3C0180F0};
        tbl[3] = '{1'b0, 1'b0, 32'h1E0180F0, 32'h7880010F};
        tbl[4] = '{1'b1, 1'b0, 32'hA5A5005A, 32'hA5A5005A};

        do_reset();
        chk("rst_valid1", if1.out_valid, 0);
        chk("rst_data1",  if1.out_data,  0);
        chk("rst_lock1",  sl1, 0);
        chk("rst_ovf1",   ov1, 0);
        chk("rst_perr1",  pe1, 0);
        chk("rst_valid2", if2.out_valid, 0);
        chk("rst_lock2",  sl2, 0);

        for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // overflow with consumer stalled, then clear and drain
        do_reset();
        if1.out_ready = 1'b0;
        msb_first     = 1'b1;
        send_byte(8'hA5, 1'b0);
        send_pbyte(8'h11, 1'b0); send_pbyte(8'h22, 1'b0);
        send_pbyte(8'h33, 1'b0); send_pbyte(8'h44, 1'b0);
        chk("ovf_full_valid", if1.out_valid, 1);
        chk("ovf_head",       if1.out_data,  8'h11);
        chk("ovf_not_yet",    ov1, 0);
        send_byte(8'hA5, 1'b0);
        send_pbyte(8'h55, 1'b0);
        chk("ovf_set",        ov1, 1);
        chk("ovf_head_kept",  if1.out_data, 8'h11);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clear",      ov1, 0);
        drain1(6);
        chk_got1("ovf_drain", 32'h11223344);
        chk("ovf_empty",      if1.out_valid, 0);
        chk("ovf_data_hold",  if1.out_data,  8'h44);

        // full FIFO with a pop on the same edge as the completing bit
        do_reset();
        if1.out_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_pbyte(8'h11, 1'b0); send_pbyte(8'h22, 1'b0);
        send_pbyte(8'h33, 1'b0); send_pbyte(8'h44, 1'b0);
        send_byte(8'hA5, 1'b0);
        bits = {8'h55, ^8'h55};
        for (int i = 0; i < BPB; i++) begin
            if (i == BPB - 1) if1.out_ready = 1'b1;
            send_bit(bits[8-i]);
        end
        if1.out_ready = 1'b0;
        chk("fullpop_ovf",   ov1, 0);
        chk("fullpop_valid", if1.out_valid, 1);
        chk("fullpop_head",  if1.out_data, 8'h22);
        drain1(6);
        chk_got1("fullpop_drain", 32'h22334455);

        // asynchronous reset in the middle of a payload byte
        do_reset();
        if1.out_ready = 1'b0;
        msb_first     = 1'b1;
        send_byte(8'hA5, 1'b0);
        send_pbyte(8'h11, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("mid_pre_lock",  sl1, 1);
        chk("mid_pre_valid", if1.out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", if1.out_valid, 0);
        chk("mid_rst_data",  if1.out_data,  0);
        chk("mid_rst_lock",  sl1, 0);
        chk("mid_rst_ovf",   ov1, 0);
        chk("mid_rst_perr",  pe1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(tbl[0], "post_rst");

        // bit direction, proven with the non-palindromic sync 0x1E
        dir_pay = '{8'h3C, 8'h5A, 8'h01, 8'h80, 8'hFF, 8'h00};
        do_reset();
        msb_first     = 1'b0;
        if2.out_ready = 1'b1;
        got2.delete();
        collect_en    = 1'b1;
        send_byte(8'h1E, 1'b1);
        chk("dir_lock_lsb", sl2, 1);
        for (int k = 0; k < 6; k++) send_pbyte(dir_pay[k], 1'b1);
        chk("dir_unlock", sl2, 0);
        repeat (4) tick();
        collect_en = 1'b0;
        chk("dir_count", got2.size(), 6);
        for (int k = 0; k < 6 && k < got2.size(); k++) chk("dir_byte", got2[k], dir_pay[k]);
        do_reset();
        msb_first = 1'b0;
        send_byte(8'h1E, 1'b0);
        chk("dir_nolock", sl2, 0);
        do_reset();
        msb_first = 1'b1;
        send_byte(8'h1E, 1'b0);
        chk("dir_lock_msb", sl2, 1);

`ifdef PARITY_CHECK_EN
        // good parity accepted, bad parity dropped and flagged
        do_reset();
        msb_first     = 1'b1;
        if1.out_ready = 1'b1;
        got1.delete();
        collect_en    = 1'b1;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0); send_bit(1'b1);
        send_byte(8'h07, 1'b0); send_bit(1'b0);
        chk("par_err", pe1, 1);
        send_pbyte(8'h11, 1'b0);
        send_pbyte(8'h22, 1'b0);
        repeat (4) tick();
        collect_en = 1'b0;
        chk("par_count", got1.size(), 3);
        if (got1.size() == 3) begin
            chk("par_b0", got1[0], 8'h07);
            chk("par_b1", got1[1], 8'h11);
            chk("par_b2", got1[2], 8'h22);
        end
`endif

        // randomized run against the model, both DUTs on the same stream
        do_reset();
        model_reset();
        model_en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bits_q.size() == 0) begin
                r  = $urandom_range(0, 9);
                lo = 1'($urandom_range(0, 1));
                msb_first = ~lo;
                if ($urandom_range(0, 7) == 0) msb_first = lo;
                if (r < 3)      b = 8'hA5;
                else if (r < 5) b = 8'h1E;
                else            b = 8'($urandom);
                for (int i = 0; i < 8; i++) bits_q.push_back(lo ? {7'd0, b[i]} : {7'd0, b[7-i]});
                if (BPB == 9 && r >= 5) bits_q.push_back(8'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 49) == 0) msb_first = ~msb_first;
            if ($urandom_range(0, 4) != 0) begin
                sin    = bits_q[0][0];
                sin_en = 1'b1;
                void'(bits_q.pop_front());
            end else begin
                sin    = 1'($urandom_range(0, 1));
                sin_en = 1'b0;
            end
            case ((cyc / 100) % 3)
                0:       begin if1.out_ready = ($urandom_range(0, 7) != 0); if2.out_ready = ($urandom_range(0, 7) != 0); end
                1:       begin if1.out_ready = ($urandom_range(0, 15) == 0); if2.out_ready = ($urandom_range(0, 15) == 0); end
                default: begin if1.out_ready = 1'($urandom_range(0, 1)); if2.out_ready = 1'($urandom_range(0, 1)); end
            endcase
            clr_err = ($urandom_range(0, 19) == 0);
            tick();
        end
        model_en = 1'b0;
        sin_en   = 1'b0;
        clr_err  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
